// File: rtl/pwm_deadtime_gen.sv
// Complementary gate driver with programmable dead time, enable and latched fault.
// Optional PULSE_DROP_CNT_EN adds a saturating counter of aborted dead intervals.
module pwm_deadtime_gen #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault,
    input  logic                fault_clr,
    output logic                hs_out,
    output logic                ls_out,
`ifdef PULSE_DROP_CNT_EN
    output logic [7:0]          drop_cnt,
`endif
    output logic                fault_latched
);

    typedef enum logic [2:0] {IDLE, DT_HS, HS_ON, DT_LS, LS_ON, FAULT} state_t;

    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                from_idle_q, from_idle_d;
    logic                abort;
    logic                hs_q, ls_q, flt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        from_idle_d = from_idle_q;
        abort       = 1'b0;
        if (fault) begin
            state_d = FAULT;
            cnt_d   = '0;
        end else if (state_q == FAULT) begin
            if (fault_clr) state_d = IDLE;
        end else if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    from_idle_d = 1'b1;
                    cnt_d       = dead_time;
                    if (pwm_in) state_d = (dead_time == '0) ? HS_ON : DT_HS;
                    else        state_d = (dead_time == '0) ? LS_ON : DT_LS;
                end
                LS_ON: if (pwm_in) begin
                    from_idle_d = 1'b0;
                    cnt_d       = dead_time;
                    state_d     = (dead_time == '0) ? HS_ON : DT_HS;
                end
                HS_ON: if (!pwm_in) begin
                    from_idle_d = 1'b0;
                    cnt_d       = dead_time;
                    state_d     = (dead_time == '0) ? LS_ON : DT_LS;
                end
                // An abort out of an IDLE entry has no previous ON side, so it restarts toward the other side.
                DT_HS: if (!pwm_in) begin
                    abort = 1'b1;
                    if (from_idle_q) begin
                        cnt_d   = dead_time;
                        state_d = (dead_time == '0) ? LS_ON : DT_LS;
                    end else begin
                        cnt_d   = '0;
                        state_d = LS_ON;
                    end
                end else if (cnt_q <= 1) begin
                    cnt_d   = '0;
                    state_d = HS_ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                DT_LS: if (pwm_in) begin
                    abort = 1'b1;
                    if (from_idle_q) begin
                        cnt_d   = dead_time;
                        state_d = (dead_time == '0) ? HS_ON : DT_HS;
                    end else begin
                        cnt_d   = '0;
                        state_d = HS_ON;
                    end
                end else if (cnt_q <= 1) begin
                    cnt_d   = '0;
                    state_d = LS_ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            from_idle_q <= 1'b0;
            hs_q        <= 1'b0;
            ls_q        <= 1'b0;
            flt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            from_idle_q <= from_idle_d;
            hs_q        <= (state_d == HS_ON);
            ls_q        <= (state_d == LS_ON);
            flt_q       <= (state_d == FAULT);
        end
    end

    assign hs_out        = hs_q;
    assign ls_out        = ls_q;
    assign fault_latched = flt_q;

`ifdef PULSE_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (state_q == FAULT && !fault && fault_clr) begin
            drop_q <= '0;
        end else if (abort && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen: side/pending-side reference model checked every cycle plus directed literal checks.
module tb_pwm_deadtime_gen;

    logic       clk = 1'b0;
    logic       rst_n, en, pwm_in, fault, fault_clr;
    logic [7:0] dead_time;
    logic       hs_out, ls_out, fault_latched;
`ifdef PULSE_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pwm_deadtime_gen #(.DT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in), .dead_time(dead_time),
        .fault(fault), .fault_clr(fault_clr), .hs_out(hs_out), .ls_out(ls_out),
`ifdef PULSE_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    // Model: which side conducts (0 none, 1 high, 2 low), which side we are heading to,
    // cycles of dead time left, and the side to fall back to on a short pulse.
    int m_side, m_pend, m_left, m_home, m_want, m_drop;
    bit m_flt;

    task automatic go_side(input int w);
        if (dead_time == 0) begin
            m_side = w; m_pend = 0;
        end else begin
            m_side = 0; m_pend = w; m_left = dead_time;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_side = 0; m_pend = 0; m_left = 0; m_home = 0; m_flt = 0; m_drop = 0;
        end else if (fault) begin
            m_flt = 1; m_side = 0; m_pend = 0;
        end else if (m_flt) begin
            if (fault_clr) begin m_flt = 0; m_drop = 0; m_home = 0; end
        end else if (!en) begin
            m_side = 0; m_pend = 0;
        end else begin
            m_want = pwm_in ? 1 : 2;
            if (m_pend != 0) begin
                if (m_want != m_pend) begin
                    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                    if (m_home != 0) begin m_side = m_home; m_pend = 0; end
                    else go_side(m_want);
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_side = m_pend; m_pend = 0; end
                end
            end else if (m_side != m_want) begin
                m_home = m_side;
                go_side(m_want);
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (hs_out !== (m_side == 1) || ls_out !== (m_side == 2) || fault_latched !== m_flt) begin
            errors++;
            $display("FAIL model t=%0t hs/ls/flt got %b%b%b want %b%b%b", $time,
                     hs_out, ls_out, fault_latched, m_side == 1, m_side == 2, m_flt);
        end
        checks++;
        if (hs_out === 1'b1 && ls_out === 1'b1) begin
            errors++;
            $display("FAIL overlap t=%0t hs=1 ls=1 want never both 1", $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic h, input logic l, input logic f);
        checks++;
        if (hs_out !== h || ls_out !== l || fault_latched !== f) begin
            errors++;
            $display("FAIL %s hs/ls/flt got %b%b%b want %b%b%b", nm,
                     hs_out, ls_out, fault_latched, h, l, f);
        end
    endtask

`ifdef PULSE_DROP_CNT_EN
    task automatic chk_drop(input string nm, input logic [7:0] v);
        checks++;
        if (drop_cnt !== v) begin
            errors++;
            $display("FAIL %s drop_cnt got %0d want %0d", nm, drop_cnt, v);
        end
    endtask
`endif

    initial begin
        rst_n = 0; en = 0; pwm_in = 0; fault = 0; fault_clr = 0; dead_time = 8'd3;
        step(); step();
        chk("reset", 0, 0, 0);

        // Entry from IDLE toward the low side
        rst_n = 1; en = 1;
        step(); chk("entry_e0", 0, 0, 0);
        step(); chk("entry_e1", 0, 0, 0);
        step(); chk("entry_e2", 0, 0, 0);
        step(); chk("entry_ls_on", 0, 1, 0);

        // Rising transition with 3 cycles dead time, then falling
        pwm_in = 1;
        step(); chk("ls_fall", 0, 0, 0);
        step(); step(); chk("dt_hold", 0, 0, 0);
        step(); chk("hs_rise", 1, 0, 0);
        repeat (6) step();
        chk("hs_hold", 1, 0, 0);
        pwm_in = 0;
        step(); chk("hs_fall", 0, 0, 0);
        step(); step(); chk("dt_hold2", 0, 0, 0);
        step(); chk("ls_rise", 0, 1, 0);

        // One-cycle pulse shorter than dead time is dropped
        dead_time = 8'd5; pwm_in = 1;
        step(); chk("pulse_dt", 0, 0, 0);
        pwm_in = 0;
        step(); chk("pulse_back", 0, 1, 0);
        repeat (6) step();
        chk("pulse_stay", 0, 1, 0);
`ifdef PULSE_DROP_CNT_EN
        chk_drop("drop_one", 8'd1);
`endif

        // Fault latch and release
        dead_time = 8'd3; pwm_in = 1;
        repeat (4) step();
        chk("pre_fault_hs", 1, 0, 0);
        fault = 1;
        step(); chk("fault_on", 0, 0, 1);
        fault_clr = 1;
        step(); chk("clr_ignored", 0, 0, 1);
        fault = 0; fault_clr = 0;
        step(); chk("fault_held", 0, 0, 1);
        fault_clr = 1;
        step(); chk("fault_exit", 0, 0, 0);
`ifdef PULSE_DROP_CNT_EN
        chk_drop("drop_cleared", 8'd0);
`endif
        fault_clr = 0;
        step(); step(); step(); chk("refault_dt", 0, 0, 0);
        step(); chk("refault_hs", 1, 0, 0);

        // Zero dead time: both sides swap on the same edge
        dead_time = 8'd0;
        for (int i = 0; i < 4; i++) begin
            pwm_in = (i % 2 == 1);
            step();
            chk($sformatf("dt0_swap%0d", i), pwm_in, !pwm_in, 0);
            repeat (3) step();
        end

        // Enable low forces IDLE; re-entry with zero dead time is immediate
        en = 0;
        step(); chk("en_off", 0, 0, 0);
        en = 1; pwm_in = 1;
        step(); chk("idle_dt0", 1, 0, 0);

        // Asynchronous reset while conducting and while in dead time
        #3 rst_n = 0;
        #1 chk("rst_async_hs", 0, 0, 0);
        step();
        rst_n = 1; dead_time = 8'd4;
        step(); chk("dt_hs_enter", 0, 0, 0);
        step();
        #3 rst_n = 0;
        #1 chk("rst_async_dt", 0, 0, 0);
        step();
        rst_n = 1; pwm_in = 0; dead_time = 8'd3;
        step(); step(); step(); chk("rst_reentry_dt", 0, 0, 0);
        step(); chk("rst_reentry_ls", 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
